dcache_ctrl: RTL and testbench



---
 rtl/dcache_pkg.sv | 33 +++
 rtl/dcache_array.sv | 60 ++++++
 rtl/dcache_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and default geometry for the direct-mapped write-through data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_REFILL     = 2'd1,
        ST_WRITE_WAIT = 2'd2
    } state_e;

    localparam int DC_SETS       = 64;
    localparam int DC_LINE_WORDS = 4;
    localparam int DC_ADDR_W     = 32;
    localparam int DC_OFFSET_W   = 2 + $clog2(DC_LINE_WORDS);
    localparam int DC_INDEX_W    = $clog2(DC_SETS);
    localparam int DC_TAG_W      = DC_ADDR_W - DC_OFFSET_W - DC_INDEX_W;

    // Replace bytes whose active-low enable is 0, keep the rest.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  bweb);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (!bweb[b]) begin
                res[8*b +: 8] = new_w[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_w[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage in flops: combinational lookup, full-line refill write,
// byte-masked single-word store write. Only the valid bits are reset.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int SETS       = DC_SETS,
    parameter int LINE_WORDS = DC_LINE_WORDS,
    parameter int TAG_W      = DC_TAG_W,
    localparam int INDEX_W   = $clog2(SETS),
    localparam int WSEL_W    = $clog2(LINE_WORDS)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [INDEX_W-1:0]      rd_index_i,
    input  logic [WSEL_W-1:0]       rd_word_i,
    output logic                    rd_valid_o,
    output logic [TAG_W-1:0]        rd_tag_o,
    output logic [31:0]             rd_data_o,
    input  logic                    lw_en_i,
    input  logic [INDEX_W-1:0]      lw_index_i,
    input  logic [TAG_W-1:0]        lw_tag_i,
    input  logic [LINE_WORDS*32-1:0] lw_data_i,
    input  logic                    ww_en_i,
    input  logic [INDEX_W-1:0]      ww_index_i,
    input  logic [WSEL_W-1:0]       ww_word_i,
    input  logic [31:0]             ww_wdata_i,
    input  logic [3:0]              ww_bweb_i
);

    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [31:0]      data_q [SETS][LINE_WORDS];

    // Valid bits: cleared by reset, set when a refill completes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else if (lw_en_i) begin
            valid_q[lw_index_i] <= 1'b1;
        end
    end

    // Tag and data contents; refill and store hit never coincide.
    always_ff @(posedge clk_i) begin
        if (lw_en_i) begin
            tag_q[lw_index_i] <= lw_tag_i;
            for (int w = 0; w < LINE_WORDS; w++) begin
                data_q[lw_index_i][w] <= lw_data_i[w*32 +: 32];
            end
        end else if (ww_en_i) begin
            data_q[ww_index_i][ww_word_i] <=
                merge_bytes(data_q[ww_index_i][ww_word_i], ww_wdata_i, ww_bweb_i);
        end
    end

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_data_o  = data_q[rd_index_i][rd_word_i];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, write-no-allocate data cache controller sitting
// between the CPU data port and the AXI master FSM.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int SETS       = DC_SETS,
    parameter int LINE_WORDS = DC_LINE_WORDS,
    parameter int ADDR_W     = DC_ADDR_W
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [31:0]       core_wdata,
    input  logic [3:0]        core_bweb,
    output logic [31:0]       core_rdata,
    output logic              core_wait,
    output logic              ARvalid,
    output logic [ADDR_W-1:0] read_addr,
    input  logic              read_data_valid,
    input  logic [31:0]       read_data,
    input  logic              Rlast,
    output logic              AWvalid,
    output logic [ADDR_W-1:0] write_addr,
    output logic [31:0]       write_data,
    output logic [3:0]        write_bweb,
    input  logic              write_done
);

    localparam int WSEL_W   = $clog2(LINE_WORDS);
    localparam int OFFSET_W = 2 + WSEL_W;
    localparam int INDEX_W  = $clog2(SETS);
    localparam int TAG_W    = ADDR_W - OFFSET_W - INDEX_W;
    localparam logic [WSEL_W-1:0] CNT_ONE = WSEL_W'(1);

    state_e                    state_q, state_d;
    logic [WSEL_W-1:0]         cnt_q, cnt_d;
    logic [LINE_WORDS*32-1:0]  line_q, line_d;
    logic                      skip_q, skip_d;

    logic [WSEL_W-1:0]  word_s;
    logic [INDEX_W-1:0] index_s;
    logic [TAG_W-1:0]   tag_s;
    logic               addr_unused_s;
    logic               arr_valid_s;
    logic [TAG_W-1:0]   arr_tag_s;
    logic [31:0]        arr_data_s;
    logic               hit_s, load_s, store_s, aw_fire_s, refill_last_s;

    assign word_s        = core_addr[OFFSET_W-1:2];
    assign index_s       = core_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
    assign tag_s         = core_addr[ADDR_W-1:OFFSET_W+INDEX_W];
    assign addr_unused_s = ^core_addr[1:0];

    assign hit_s         = arr_valid_s & (arr_tag_s == tag_s);
    assign load_s        = core_req & ~core_we;
    assign store_s       = core_req & core_we;
    assign aw_fire_s     = (state_q == ST_IDLE) & store_s & write_done;
    assign refill_last_s = (state_q == ST_REFILL) & read_data_valid & Rlast;

    dcache_array #(
        .SETS       (SETS),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (TAG_W)
    ) u_array (
        .clk_i      (ACLK),
        .rst_ni     (ARESETn),
        .rd_index_i (index_s),
        .rd_word_i  (word_s),
        .rd_valid_o (arr_valid_s),
        .rd_tag_o   (arr_tag_s),
        .rd_data_o  (arr_data_s),
        .lw_en_i    (refill_last_s),
        .lw_index_i (index_s),
        .lw_tag_i   (tag_s),
        .lw_data_i  (line_d),
        .ww_en_i    (aw_fire_s & hit_s),
        .ww_index_i (index_s),
        .ww_word_i  (word_s),
        .ww_wdata_i (core_wdata),
        .ww_bweb_i  (core_bweb)
    );

    // State register with refill beat counter, line buffer and write-wait skip flag.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            line_q  <= '0;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            skip_q  <= skip_d;
        end
    end

    // Next-state logic; the final beat is merged into line_d so the array sees the full line.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        skip_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_s & ~hit_s) begin
                    state_d = ST_REFILL;
                    cnt_d   = '0;
                end else if (aw_fire_s) begin
                    state_d = ST_WRITE_WAIT;
                    skip_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REFILL: begin
                if (read_data_valid) begin
                    line_d[{cnt_q, 5'd0} +: 32] = read_data;
                    cnt_d = cnt_q + CNT_ONE;
                    if (Rlast) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_REFILL;
                    end
                end else begin
                    state_d = ST_REFILL;
                end
            end
            ST_WRITE_WAIT: begin
                // write_done in the skip cycle still shows the pre-request state.
                if (!skip_q && write_done) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WRITE_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode: hits and the one-cycle master pulses are driven from IDLE.
    always_comb begin
        core_rdata = 32'h0000_0000;
        core_wait  = 1'b0;
        ARvalid    = 1'b0;
        read_addr  = '0;
        AWvalid    = 1'b0;
        write_addr = '0;
        write_data = 32'h0000_0000;
        write_bweb = 4'hF;
        case (state_q)
            ST_IDLE: begin
                if (load_s) begin
                    if (hit_s) begin
                        core_rdata = arr_data_s;
                    end else begin
                        ARvalid   = 1'b1;
                        read_addr = {core_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                        core_wait = 1'b1;
                    end
                end else if (store_s) begin
                    core_wait = 1'b1;
                    if (write_done) begin
                        AWvalid    = 1'b1;
                        write_addr = core_addr;
                        write_data = core_wdata;
                        write_bweb = core_bweb;
                    end else begin
                        AWvalid = 1'b0;
                    end
                end else begin
                    core_wait = 1'b0;
                end
            end
            ST_REFILL: begin
                core_wait = 1'b1;
            end
            ST_WRITE_WAIT: begin
                core_wait = skip_q | ~write_done;
            end
            default: begin
                core_wait = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios then randomized accesses,
// checked against a memory + resident-line model of the cache.
module tb_dcache_ctrl;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        core_req = 1'b0;
    logic        core_we = 1'b0;
    logic [31:0] core_addr = 32'h0;
    logic [31:0] core_wdata = 32'h0;
    logic [3:0]  core_bweb = 4'hF;
    logic [31:0] core_rdata;
    logic        core_wait;
    logic        ARvalid;
    logic [31:0] read_addr;
    logic        read_data_valid = 1'b0;
    logic [31:0] read_data = 32'h0;
    logic        Rlast = 1'b0;
    logic        AWvalid;
    logic [31:0] write_addr;
    logic [31:0] write_data;
    logic [3:0]  write_bweb;
    logic        write_done = 1'b1;

    always #5 ACLK = ~ACLK;

    dcache_ctrl dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_bweb(core_bweb),
        .core_rdata(core_rdata), .core_wait(core_wait),
        .ARvalid(ARvalid), .read_addr(read_addr),
        .read_data_valid(read_data_valid), .read_data(read_data), .Rlast(Rlast),
        .AWvalid(AWvalid), .write_addr(write_addr), .write_data(write_data),
        .write_bweb(write_bweb), .write_done(write_done)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: backing memory plus which line each set currently holds.
    bit [31:0]   mem [int unsigned];
    bit          m_valid [64];
    int unsigned m_line  [64];

    function automatic bit [31:0] mem_rd(input int unsigned a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic check_idle(input string tag);
        @(negedge ACLK);
        core_req = 1'b0;
        read_data_valid = 1'b0;
        Rlast = 1'b0;
        write_done = 1'b1;
        #1;
        chk({tag, "_wait"},  {31'd0, core_wait}, 32'd0);
        chk({tag, "_ar"},    {31'd0, ARvalid},   32'd0);
        chk({tag, "_aw"},    {31'd0, AWvalid},   32'd0);
        chk({tag, "_rdata"}, core_rdata,         32'd0);
    endtask

    task automatic access(input bit we, input bit [31:0] addr, input bit [31:0] wdata,
                          input bit [3:0] bweb, input int busy_pre, input int lat,
                          input int wd_delay, input int rst_beat, output bit [31:0] rdata_o);
        int unsigned line;
        int          idx;
        bit          exp_hit;
        bit [31:0]   exp_data;
        bit [31:0]   merged;
        bit          plan[$];
        bit          wdq[$];
        int          beat, cyc, done_cyc, ar_cnt, aw_cnt, rlast_cyc, exp_done;
        bit          rd_on, aborted;
        line = addr >> 4;
        idx = int'(line % 64);
        exp_hit = m_valid[idx] && (m_line[idx] == line);
        exp_data = mem_rd(addr);
        beat = 0; cyc = 0; done_cyc = -1; ar_cnt = 0; aw_cnt = 0; rlast_cyc = -1;
        rd_on = 1'b0; aborted = 1'b0; rdata_o = 32'h0;
        for (int i = 0; i < busy_pre; i++) wdq.push_back(1'b0);
        while (cyc < 200 && done_cyc < 0 && !aborted) begin
            @(negedge ACLK);
            core_req = 1'b1; core_we = we; core_addr = addr;
            core_wdata = wdata; core_bweb = bweb;
            read_data_valid = 1'b0; Rlast = 1'b0; read_data = 32'h0;
            if (rd_on && plan.size() > 0) begin
                if (plan.pop_front()) begin
                    read_data_valid = 1'b1;
                    read_data = mem_rd((line << 4) + beat * 4);
                    Rlast = (beat == 3);
                    if (beat == 3) rlast_cyc = cyc;
                    beat++;
                end
            end
            write_done = (wdq.size() > 0) ? wdq.pop_front() : 1'b1;
            if (rst_beat >= 0 && read_data_valid && beat == rst_beat) begin
                ARESETn = 1'b0; core_req = 1'b0; read_data_valid = 1'b0; Rlast = 1'b0;
                #1;
                chk("rst_ar",    {31'd0, ARvalid},   32'd0);
                chk("rst_wait",  {31'd0, core_wait}, 32'd0);
                chk("rst_rdata", core_rdata,         32'd0);
                #1 ARESETn = 1'b1;
                foreach (m_valid[i]) m_valid[i] = 1'b0;
                aborted = 1'b1;
            end else begin
                #1;
                if (ARvalid) begin
                    ar_cnt++;
                    chk("read_addr", read_addr, line << 4);
                    rd_on = 1'b1;
                    plan.delete();
                    for (int i = 0; i < lat; i++) plan.push_back(1'b0);
                    for (int b = 0; b < 4; b++) begin
                        if ($urandom_range(0, 1) == 1) plan.push_back(1'b0);
                        plan.push_back(1'b1);
                    end
                end
                if (AWvalid) begin
                    aw_cnt++;
                    chk("write_addr", write_addr, addr);
                    chk("write_data", write_data, wdata);
                    chk("write_bweb", {28'd0, write_bweb}, {28'd0, bweb});
                    wdq.delete();
                    wdq.push_back(1'b1);
                    for (int i = 0; i < wd_delay; i++) wdq.push_back(1'b0);
                end
                if (!core_wait) begin
                    done_cyc = cyc;
                    rdata_o = core_rdata;
                    if (!we) chk("load_data", core_rdata, exp_data);
                end
            end
            cyc++;
        end
        if (!aborted) begin
            chk("completed", {31'd0, done_cyc >= 0}, 32'd1);
            exp_done = we ? (busy_pre + 2 + wd_delay) : (exp_hit ? 0 : rlast_cyc + 1);
            chk("latency", done_cyc, exp_done);
            chk("ar_count", ar_cnt, (!we && !exp_hit) ? 1 : 0);
            chk("aw_count", aw_cnt, we ? 1 : 0);
            if (!we && !exp_hit) begin
                m_valid[idx] = 1'b1;
                m_line[idx] = line;
            end
            if (we) begin
                merged = mem_rd(addr);
                for (int b = 0; b < 4; b++) begin
                    if (!bweb[b]) merged[8*b +: 8] = wdata[8*b +: 8];
                end
                mem[addr] = merged;
            end
        end
        check_idle("idle");
    endtask

    bit [31:0] rd;

    initial begin
        mem[32'h40] = 32'h1111_1111;
        mem[32'h44] = 32'h2222_2222;
        mem[32'h48] = 32'h3333_3333;
        mem[32'h4C] = 32'h4444_4444;
        foreach (m_valid[i]) m_valid[i] = 1'b0;

        repeat (2) @(negedge ACLK);
        #1;
        chk("reset_wait",  {31'd0, core_wait}, 32'd0);
        chk("reset_ar",    {31'd0, ARvalid},   32'd0);
        chk("reset_aw",    {31'd0, AWvalid},   32'd0);
        chk("reset_rdata", core_rdata,         32'd0);
        @(negedge ACLK);
        ARESETn = 1'b1;

        access(1'b0, 32'h40, 32'h0, 4'hF, 0, 2, 0, -1, rd);
        chk("tp_cold_load", rd, 32'h1111_1111);
        access(1'b0, 32'h4C, 32'h0, 4'hF, 0, 0, 0, -1, rd);
        chk("tp_hit_4c", rd, 32'h4444_4444);
        access(1'b1, 32'h44, 32'hAABB_CCDD, 4'b1100, 0, 0, 1, -1, rd);
        access(1'b0, 32'h44, 32'h0, 4'hF, 0, 0, 0, -1, rd);
        chk("tp_merged", rd, 32'h2222_CCDD);
        access(1'b1, 32'h1000, 32'h1234_5678, 4'h0, 0, 0, 2, -1, rd);
        access(1'b0, 32'h1000, 32'h0, 4'hF, 0, 1, 0, -1, rd);
        chk("tp_noalloc", rd, 32'h1234_5678);
        access(1'b1, 32'h48, 32'hDEAD_BEEF, 4'h0, 0, 0, 0, -1, rd);
        access(1'b1, 32'h4C, 32'hCAFE_F00D, 4'b0101, 5, 0, 1, -1, rd);
        access(1'b0, 32'h40, 32'h0, 4'hF, 0, 0, 0, -1, rd);
        access(1'b0, 32'h440, 32'h0, 4'hF, 0, 1, 0, -1, rd);
        access(1'b0, 32'h40, 32'h0, 4'hF, 0, 0, 0, -1, rd);
        access(1'b0, 32'h80, 32'h0, 4'hF, 0, 1, 0, 2, rd);
        access(1'b0, 32'h80, 32'h0, 4'hF, 0, 0, 0, -1, rd);

        for (int n = 0; n < 250; n++) begin
            bit [31:0] a;
            bit        w;
            a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 4) | ($urandom_range(0, 3) << 2);
            w = ($urandom_range(0, 9) < 4);
            access(w, a, $urandom, 4'($urandom_range(0, 15)),
                   w ? $urandom_range(0, 3) : 0, $urandom_range(0, 3),
                   $urandom_range(0, 4), -1, rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
